// File: rtl/fp_exp_align_pipe_pkg.sv
// Shared format constants for the FP adder alignment front end.
package fp_align_pkg;

    // Single-precision field widths (significand includes the hidden bit)
    localparam int unsigned SP_EXP_W = 8;
    localparam int unsigned SP_MAN_W = 24;

    // Double-precision field widths (significand includes the hidden bit)
    localparam int unsigned DP_EXP_W = 11;
    localparam int unsigned DP_MAN_W = 53;

    // Guard, round and sticky bits appended below the significand
    localparam int unsigned GRS_W = 3;

endpackage : fp_align_pkg

// File: rtl/fp_exp_align_pipe_rshift.sv
// Combinational right shift that folds every shifted-out bit into bit 0 (sticky).
// Shift amounts of W or more leave only the sticky bit.
module fp_rshift_sticky #(
    parameter int unsigned W    = 56,
    parameter int unsigned SH_W = 6
) (
    input  logic [W-1:0]    din_i,
    input  logic [SH_W-1:0] sh_i,
    output logic [W-1:0]    dout_c_o
);

    logic [W-1:0] shifted;
    logic [W-1:0] lost_mask;

    // Shift, then OR the bits that fell off the bottom into the LSB
    always_comb begin
        shifted      = din_i >> sh_i;
        lost_mask    = ~({W{1'b1}} << sh_i);
        dout_c_o     = shifted;
        dout_c_o[0]  = shifted[0] | (|(din_i & lost_mask));
    end

endmodule : fp_rshift_sticky

// File: rtl/fp_exp_align_pipe.sv
// Two-stage exponent compare / significand align front end for the FP adder.
// Stage 1 orders the operands by exponent; stage 2 aligns the smaller one.
module fp_exp_align_pipe
    import fp_align_pkg::*;
#(
    parameter int unsigned EXP_W = DP_EXP_W,
    parameter int unsigned MAN_W = DP_MAN_W,
    localparam int unsigned ALN_W = MAN_W + GRS_W,
    localparam int unsigned SH_W  = $clog2(ALN_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] ea,
    input  logic [EXP_W-1:0] eb,
    input  logic [MAN_W-1:0] ma,
    input  logic [MAN_W-1:0] mb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] e_big,
    output logic [ALN_W-1:0] m_big,
    output logic [ALN_W-1:0] m_small,
    output logic             eb_gt_ea,
    output logic [EXP_W-1:0] as
);

    // Stage-1 register contents: ordered operands plus saturated shift
    typedef struct packed {
        logic [EXP_W-1:0] e_big;
        logic [MAN_W-1:0] m_b;
        logic [MAN_W-1:0] m_s;
        logic [SH_W-1:0]  sh;
        logic [EXP_W-1:0] as;
        logic             eb_gt_ea;
    } align_s;

    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    align_s           s1_q, s1_d;
    logic [EXP_W-1:0] e_big_q, e_big_d;
    logic [EXP_W-1:0] as_q, as_d;
    logic [ALN_W-1:0] m_big_q, m_big_d;
    logic [ALN_W-1:0] m_small_q, m_small_d;
    logic             gt_q, gt_d;
    logic             ld1, ld2;
    logic             gt_c;
    logic [EXP_W-1:0] diff_c;
    logic [ALN_W-1:0] m_small_c;

    // Stage 2 loads when empty or draining; stage 1 when empty or moving into stage 2
    always_comb begin
        ld2      = !v2_q || out_ready;
        ld1      = !v1_q || ld2;
        in_ready = ld1;
        v1_d     = ld1 ? in_valid : v1_q;
        v2_d     = ld2 ? v1_q : v2_q;
    end

    // Stage 1: compare exponents, swap operands, clamp the shift amount
    always_comb begin
        s1_d   = s1_q;
        gt_c   = (eb > ea);
        diff_c = gt_c ? (eb - ea) : (ea - eb);
        if (ld1 && in_valid) begin
            s1_d.eb_gt_ea = gt_c;
            s1_d.as       = diff_c;
            s1_d.e_big    = gt_c ? eb : ea;
            s1_d.m_b      = gt_c ? mb : ma;
            s1_d.m_s      = gt_c ? ma : mb;
            if (32'(diff_c) >= ALN_W) begin
                s1_d.sh = SH_W'(ALN_W);
            end else begin
                s1_d.sh = SH_W'(diff_c);
            end
        end
    end

    fp_rshift_sticky #(
        .W    (ALN_W),
        .SH_W (SH_W)
    ) u_rshift (
        .din_i    ({s1_q.m_s, {GRS_W{1'b0}}}),
        .sh_i     (s1_q.sh),
        .dout_c_o (m_small_c)
    );

    // Stage 2: capture aligned significands and pass-through fields
    always_comb begin
        e_big_d   = e_big_q;
        as_d      = as_q;
        gt_d      = gt_q;
        m_big_d   = m_big_q;
        m_small_d = m_small_q;
        if (ld2 && v1_q) begin
            e_big_d   = s1_q.e_big;
            as_d      = s1_q.as;
            gt_d      = s1_q.eb_gt_ea;
            m_big_d   = {s1_q.m_b, {GRS_W{1'b0}}};
            m_small_d = m_small_c;
        end
    end

    // Pipeline state; reset flushes both stages and clears outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            s1_q      <= '0;
            e_big_q   <= '0;
            as_q      <= '0;
            gt_q      <= 1'b0;
            m_big_q   <= '0;
            m_small_q <= '0;
        end else begin
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            s1_q      <= s1_d;
            e_big_q   <= e_big_d;
            as_q      <= as_d;
            gt_q      <= gt_d;
            m_big_q   <= m_big_d;
            m_small_q <= m_small_d;
        end
    end

    assign out_valid = v2_q;
    assign e_big     = e_big_q;
    assign as        = as_q;
    assign eb_gt_ea  = gt_q;
    assign m_big     = m_big_q;
    assign m_small   = m_small_q;

endmodule : fp_exp_align_pipe

// File: tb/tb_fp_exp_align_pipe.sv
// Directed bench for fp_exp_align_pipe at double and single precision.
module tb_fp_exp_align_pipe;
    import fp_align_pkg::*;

    localparam int unsigned EW  = DP_EXP_W;
    localparam int unsigned MW  = DP_MAN_W;
    localparam int unsigned AW  = DP_MAN_W + GRS_W;
    localparam int unsigned SEW = SP_EXP_W;
    localparam int unsigned SMW = SP_MAN_W;
    localparam int unsigned SAW = SP_MAN_W + GRS_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Double-precision DUT signals
    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [EW-1:0] ea = '0, eb = '0, e_big, as_o;
    logic [MW-1:0] ma = '0, mb = '0;
    logic [AW-1:0] m_big, m_small;
    logic          gt;

    // Single-precision DUT signals
    logic           s_in_valid = 1'b0, s_in_ready, s_out_valid;
    logic [SEW-1:0] s_ea = '0, s_eb = '0, s_e_big, s_as;
    logic [SMW-1:0] s_ma = '0, s_mb = '0;
    logic [SAW-1:0] s_m_big, s_m_small;
    logic           s_gt;

    fp_exp_align_pipe #(.EXP_W(EW), .MAN_W(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ea(ea), .eb(eb), .ma(ma), .mb(mb),
        .out_valid(out_valid), .out_ready(out_ready),
        .e_big(e_big), .m_big(m_big), .m_small(m_small),
        .eb_gt_ea(gt), .as(as_o)
    );

    fp_exp_align_pipe #(.EXP_W(SEW), .MAN_W(SMW)) dut_sp (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .ea(s_ea), .eb(s_eb), .ma(s_ma), .mb(s_mb),
        .out_valid(s_out_valid), .out_ready(1'b1),
        .e_big(s_e_big), .m_big(s_m_big), .m_small(s_m_small),
        .eb_gt_ea(s_gt), .as(s_as)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One double-precision pair through an idle pipe
    task automatic run_dp(input string tag,
                          input logic [EW-1:0] a_e, input logic [EW-1:0] b_e,
                          input logic [MW-1:0] a_m, input logic [MW-1:0] b_m,
                          input logic x_gt, input logic [EW-1:0] x_as, input logic [EW-1:0] x_eb,
                          input logic [AW-1:0] x_mbig, input logic [AW-1:0] x_msmall);
        @(negedge clk);
        ea = a_e; eb = b_e; ma = a_m; mb = b_m;
        in_valid = 1'b1; out_ready = 1'b1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, ".ov_early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, ".ov"}, 64'(out_valid), 64'd1);
        check({tag, ".gt"}, 64'(gt), 64'(x_gt));
        check({tag, ".as"}, 64'(as_o), 64'(x_as));
        check({tag, ".e_big"}, 64'(e_big), 64'(x_eb));
        check({tag, ".m_big"}, 64'(m_big), 64'(x_mbig));
        check({tag, ".m_small"}, 64'(m_small), 64'(x_msmall));
    endtask

    // One single-precision pair through an idle pipe
    task automatic run_sp(input string tag,
                          input logic [SEW-1:0] a_e, input logic [SEW-1:0] b_e,
                          input logic [SMW-1:0] a_m, input logic [SMW-1:0] b_m,
                          input logic x_gt, input logic [SEW-1:0] x_as, input logic [SEW-1:0] x_eb,
                          input logic [SAW-1:0] x_mbig, input logic [SAW-1:0] x_msmall);
        @(negedge clk);
        s_ea = a_e; s_eb = b_e; s_ma = a_m; s_mb = b_m;
        s_in_valid = 1'b1;
        check({tag, ".in_ready"}, 64'(s_in_ready), 64'd1);
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, ".ov"}, 64'(s_out_valid), 64'd1);
        check({tag, ".gt"}, 64'(s_gt), 64'(x_gt));
        check({tag, ".as"}, 64'(s_as), 64'(x_as));
        check({tag, ".e_big"}, 64'(s_e_big), 64'(x_eb));
        check({tag, ".m_big"}, 64'(s_m_big), 64'(x_mbig));
        check({tag, ".m_small"}, 64'(s_m_small), 64'(x_msmall));
    endtask

    // Drive streamed item i: A is big by i, B's significand shifts right by i
    task automatic drive_item(input int i);
        ea = EW'(20 + i);
        eb = EW'(20);
        ma = MW'(i + 1);
        mb = MW'(1) << 52;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [MW-1:0] hid;
        logic [AW-1:0] top;
        int acc_n, rcv_n, seen;
        logic acc, rcv;

        hid = MW'(1) << 52;
        top = AW'(1) << 55;

        // Reset values
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.e_big", 64'(e_big), 64'd0);
        check("rst.m_small", 64'(m_small), 64'd0);
        check("rst.as", 64'(as_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready", 64'(in_ready), 64'd1);

        // Directed double-precision vectors
        run_dp("equal", 11'd1, 11'd1, hid, hid, 1'b0, 11'd0, 11'd1, top, top);
        run_dp("swap", 11'd5, 11'd7, hid, hid, 1'b1, 11'd2, 11'd7, top, AW'(1) << 53);
        run_dp("sticky", 11'd10, 11'd0, hid, hid | MW'(1), 1'b0, 11'd10, 11'd10, top,
               (AW'(1) << 45) | AW'(1));
        run_dp("sat", 11'd2047, 11'd0, hid, hid | MW'(5), 1'b0, 11'd2047, 11'd2047, top, AW'(1));
        run_dp("sat_zero", 11'd2047, 11'd0, hid, MW'(0), 1'b0, 11'd2047, 11'd2047, top, AW'(0));
        run_dp("sh_aln", 11'd0, 11'd56, hid, {MW{1'b1}}, 1'b1, 11'd56, 11'd56,
               {{MW{1'b1}}, 3'b000}, AW'(1));
        run_dp("sh54", 11'd0, 11'd54, hid, hid, 1'b1, 11'd54, 11'd54, top, AW'(2));
        run_dp("sh3", 11'd3, 11'd0, hid, hid | MW'(7), 1'b0, 11'd3, 11'd3, top,
               (AW'(1) << 52) | AW'(7));

        // Directed single-precision vectors
        run_sp("sp_sticky", 8'd20, 8'd3, SMW'(1) << 23, (SMW'(1) << 23) | SMW'(1), 1'b0,
               8'd17, 8'd20, SAW'(1) << 26, (SAW'(1) << 9) | SAW'(1));
        run_sp("sp_sat", 8'd0, 8'd255, SMW'(1), SMW'(1) << 23, 1'b1, 8'd255, 8'd255,
               SAW'(1) << 26, SAW'(1));

        // Backpressure: 5-item stream, out_ready low for cycles 2..6
        acc_n = 0;
        rcv_n = 0;
        @(posedge clk); #1;
        drive_item(0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && rcv_n < 5; cyc++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            rcv = out_valid && out_ready;
            if (cyc == 2) begin
                check("bp.in_ready_full", 64'(in_ready), 64'd0);
                check("bp.accepted", 64'(acc_n), 64'd2);
            end
            if (cyc == 6) begin
                check("bp.in_ready_hold", 64'(in_ready), 64'd0);
                check("bp.ov_hold", 64'(out_valid), 64'd1);
                check("bp.e_big_hold", 64'(e_big), 64'd20);
            end
            if (rcv) begin
                check($sformatf("bp.e_big[%0d]", rcv_n), 64'(e_big), 64'(20 + rcv_n));
                check($sformatf("bp.m_small[%0d]", rcv_n), 64'(m_small), 64'(top >> rcv_n));
                rcv_n++;
            end
            @(posedge clk); #1;
            if (acc) acc_n++;
            if (acc_n < 5) begin
                drive_item(acc_n);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !((cyc + 1) >= 2 && (cyc + 1) <= 6);
        end
        check("bp.received", 64'(rcv_n), 64'd5);
        check("bp.sent", 64'(acc_n), 64'd5);
        @(negedge clk);
        check("bp.drained", 64'(out_valid), 64'd0);

        // Reset with two operand pairs in flight
        out_ready = 1'b0;
        drive_item(1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive_item(2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rmid.ov_before", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rmid.ov_now", 64'(out_valid), 64'd0);
        check("rmid.e_big", 64'(e_big), 64'd0);
        check("rmid.m_small", 64'(m_small), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rmid.stale", 64'(seen), 64'd0);
        check("rmid.in_ready", 64'(in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fp_exp_align_pipe
